// File: rtl/boreal_pwm_demod.sv
// Boreal DDS PWM receive decoder: counts synchronised rising edges per 2^WIN_LOG2-cycle window.
// Edge-to-count latency SYNC_STAGES+1 cycles; results appear the cycle after window close; no backpressure.
module boreal_pwm_demod #(
    parameter int WIN_LOG2    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [15:0] x_est,
    output logic [15:0] v_est,
    output logic        valid,
    output logic        armed
);

    localparam int SHIFT = 16 - WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] WLAST = '1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic [WIN_LOG2-1:0]      wcnt;
    logic [WIN_LOG2-1:0]      ecnt;

    logic                     rise;
    logic                     win_end;
    logic [WIN_LOG2-1:0]      ecnt_final;
    logic [16:0]              x_new;
    logic signed [16:0]       x_diff;
    logic [15:0]              v_sat;

    assign rise       = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign win_end    = (wcnt == WLAST);
    // An edge on the closing cycle belongs to the closing window, never to both.
    assign ecnt_final = ecnt + WIN_LOG2'(rise);
    assign x_new      = 17'(ecnt_final) << SHIFT;
    assign x_diff     = $signed(x_new) - $signed({1'b0, x_est});
    assign v_sat      = (x_diff > 17'sd32767) ? 16'h7fff : x_diff[15:0];

    // Synchroniser and history flop run in every state so edges are valid at re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
            ecnt  <= '0;
            x_est <= '0;
            v_est <= '0;
            valid <= 1'b0;
            armed <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    ecnt <= '0;
                    if (enable) state <= ARM;
                end
                ARM, RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        wcnt  <= '0;
                        ecnt  <= '0;
                        armed <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        if (win_end) begin
                            ecnt  <= '0;
                            x_est <= x_new[15:0];
                            if (state == RUN) begin
                                v_est <= v_sat;
                                valid <= 1'b1;
                            end
                            state <= RUN;
                            armed <= 1'b1;
                        end else begin
                            ecnt <= ecnt_final;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_pwm_demod.sv
// Randomised bench for boreal_pwm_demod against a window-sum reference model.
module tb_boreal_pwm_demod;

    localparam int WL   = 10;
    localparam int SYNC = 2;
    localparam int N    = 1 << WL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] x_est;
    logic [15:0] v_est;
    logic        valid;
    logic        armed;

    boreal_pwm_demod #(.WIN_LOG2(WL), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .pwm_in (pwm_in),
        .x_est  (x_est),
        .v_est  (v_est),
        .valid  (valid),
        .armed  (armed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int fail_prints = 0;

    // Stimulus generator: 0 = constant, 1 = square (low half first), 2 = DDS accumulator MSB
    int          gmode = 0;
    int          gconst = 0;
    int          ghalf = 1;
    int          gph = 0;
    logic [15:0] gacc = '0;
    logic [15:0] gstep = '0;

    // Reference model: pwm sample history and per-window edge sums
    bit   pa [0:65535];
    int   cyc = 16;
    int   mmode = 0;      // 0 idle, 1 arm, 2 run
    int   wstart = 0;
    int   mx = 0;
    int   mv = 0;
    logic mvalid = 1'b0;
    logic marmed = 1'b0;

    function automatic int edge_at(input int t);
        return (pa[(t - SYNC) & 65535] && !pa[(t - SYNC - 1) & 65535]) ? 1 : 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mmode = 0; mx = 0; mv = 0; mvalid = 1'b0; marmed = 1'b0;
            pa[cyc & 65535] = 1'b0;
            cyc++;
        end else begin
            pa[cyc & 65535] = pwm_in;
            mvalid = 1'b0;
            if (mmode == 0) begin
                if (enable) begin
                    mmode = 1;
                    wstart = cyc + 1;
                end
            end else if (!enable) begin
                mmode = 0;
            end else if (cyc == wstart + N - 1) begin
                int cnt;
                int xn;
                int d;
                cnt = 0;
                for (int t = wstart; t <= cyc; t++) cnt += edge_at(t);
                xn = cnt * (65536 / N);
                if (mmode == 2) begin
                    d = xn - mx;
                    mv = (d > 32767) ? 32767 : d;
                    mvalid = 1'b1;
                end
                mx = xn;
                mmode = 2;
                wstart = cyc + 1;
            end
            marmed = (mmode == 2);
            cyc++;
        end
    end

    task automatic note(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            if (fail_prints < 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
            fail_prints++;
        end
    endtask

    task automatic compare();
        checks++;
        if (x_est === mx[15:0] && v_est === mv[15:0] && valid === mvalid && armed === marmed)
            passes++;
        else begin
            fails++;
            if (fail_prints < 40)
                $display("FAIL cycle %0d: x_est=%0d v_est=%0d valid=%b armed=%b, expected %0d %0d %b %b",
                         cyc, x_est, $signed(v_est), valid, armed, mx, mv, mvalid, marmed);
            fail_prints++;
        end
    endtask

    task automatic set_gen(input int m, input int a);
        gmode = m;
        gph = 0;
        gacc = '0;
        if (m == 0) gconst = a;
        else if (m == 1) ghalf = a;
        else gstep = 16'(a);
    endtask

    task automatic step();
        if (gmode == 0) pwm_in = (gconst != 0);
        else if (gmode == 1) begin
            pwm_in = (gph >= ghalf);
            gph = (gph + 1) % (2 * ghalf);
        end else begin
            gacc = gacc + gstep;
            pwm_in = gacc[15];
        end
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (valid !== 1'b1 && n < 3 * N);
        note("valid_within_budget", int'(valid === 1'b1), 1);
    endtask

    // Called right after a valid: the next mode takes over from the first sample feeding the next-but-one window.
    task automatic align_switch(input int m, input int a);
        run(N - 1 - SYNC);
        set_gen(m, a);
    endtask

    task automatic expect_xv(input string name, input int xe, input int ve);
        note({name, "_x"}, int'(x_est), xe);
        note({name, "_v"}, int'($signed(v_est)), ve);
    endtask

    initial begin
        int n;
        // Reset with the line toggling
        set_gen(1, 1);
        run(5);
        note("reset_x", int'(x_est), 0);
        note("reset_v", int'(v_est), 0);
        note("reset_valid", int'(valid), 0);
        note("reset_armed", int'(armed), 0);

        // Period-64 square: ARM window silent, then 16 edges per window
        rst_n = 1'b1;
        set_gen(1, 32);
        enable = 1'b1;
        wait_valid(n);
        note("first_valid_latency", n, 2 * N + 1);
        expect_xv("sq64_first", 1024, 0);
        wait_valid(n);
        note("valid_period", n, N);
        expect_xv("sq64_second", 1024, 0);

        // Held high, then toggling every cycle
        align_switch(0, 1);
        wait_valid(n);
        wait_valid(n);
        expect_xv("held_one", 0, -1024);
        align_switch(1, 1);
        wait_valid(n);
        note("toggle_old_x", int'(x_est), 0);
        wait_valid(n);
        expect_xv("toggle_sat", 32768, 32767);
        wait_valid(n);
        expect_xv("toggle_steady", 32768, 0);

        // Step between periods 64 and 32
        align_switch(1, 32);
        wait_valid(n);
        note("sq64_back_old_x", int'(x_est), 32768);
        wait_valid(n);
        expect_xv("sq64_back", 1024, -31744);
        align_switch(1, 16);
        wait_valid(n);
        wait_valid(n);
        expect_xv("step_up", 2048, 1024);
        align_switch(1, 32);
        wait_valid(n);
        wait_valid(n);
        expect_xv("step_down", 1024, -1024);

        // Enable dropped mid-window, then re-armed
        run(500);
        enable = 1'b0;
        run(N + 100);
        expect_xv("disabled_hold", 1024, -1024);
        note("disabled_armed", int'(armed), 0);
        enable = 1'b1;
        wait_valid(n);
        note("rearm_latency", n, 2 * N + 1);
        expect_xv("rearm", 1024, 0);

        // DDS loopback at +3000 and -3000
        align_switch(2, 3000);
        wait_valid(n);
        wait_valid(n);
        note("dds_pos_close", int'(x_est >= 16'd2936 && x_est <= 16'd3064), 1);
        align_switch(2, -3000);
        wait_valid(n);
        wait_valid(n);
        note("dds_neg_close", int'(x_est >= 16'd2936 && x_est <= 16'd3064), 1);

        // Asynchronous reset mid-window
        run(300);
        rst_n = 1'b0;
        #1;
        note("midreset_x", int'(x_est), 0);
        note("midreset_armed", int'(armed), 0);
        run(5);
        rst_n = 1'b1;

        // Randomised segments with occasional enable drops
        for (int s = 0; s < 10; s++) begin
            int m;
            int len;
            int drop_at;
            int dlen;
            m = $urandom_range(0, 2);
            if (m == 0) set_gen(0, $urandom_range(0, 1));
            else if (m == 1) set_gen(1, $urandom_range(1, 48));
            else set_gen(2, int'($urandom));
            len = $urandom_range(300, 2500);
            drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -100;
            dlen = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if (i == drop_at) enable = 1'b0;
                if (i == drop_at + dlen) enable = 1'b1;
                step();
            end
            enable = 1'b1;
        end
        run(2 * N + 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
